exe_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; sits between the ID/EX stage register and the MEM stage.
- Consumes the decoded operands and control fields held by the ID/EX register and produces the ALU result and branch resolution.
- Registers its results into EX/MEM outputs.
- Multiplication is an iterative multi-cycle operation; while it runs, the block stalls the upstream pipeline and inserts bubbles downstream.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/iter_multiplier.sv | 73 +++++++
 rtl/exe_stage.sv | 110 +++++++++++
 tb/tb_exe_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: ALU command codes,
// branch types, multiplier FSM states and the combinational ALU function.
package mips_pkg;

  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SLL = 4'b1000;
  localparam logic [3:0] EXE_SRA = 4'b1001;
  localparam logic [3:0] EXE_SRL = 4'b1010;
  localparam logic [3:0] EXE_MUL = 4'b1100;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEZ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JMP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } exe_state_t;

  // MUL is produced by the iterative multiplier, so here it falls to zero
  // together with every undefined code.
  function automatic logic [31:0] alu_compute(input logic [3:0]  cmd,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] r;
    case (cmd)
      EXE_ADD: r = a + b;
      EXE_SUB: r = a - b;
      EXE_AND: r = a & b;
      EXE_OR:  r = a | b;
      EXE_NOR: r = ~(a | b);
      EXE_XOR: r = a ^ b;
      EXE_SLL: r = a << b[4:0];
      EXE_SRA: r = $signed(a) >>> b[4:0];
      EXE_SRL: r = a >> b[4:0];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iter_multiplier.sv
// Iterative shift-and-add multiplier producing the low 32 bits of a*b,
// retiring BITS_PER_CYCLE multiplier bits per BUSY cycle.
module iter_multiplier
  import mips_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product
);

  localparam int STEPS = 32 / BITS_PER_CYCLE;

  exe_state_t  r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [5:0]  r_count;
  logic [31:0] w_partial;
  logic [5:0]  w_count_next;

  // Only the low word is kept, so partial products may wrap freely.
  always_comb begin
    w_partial = 32'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) w_partial = w_partial + (r_mcand << i);
    end
  end

  assign w_count_next = r_count - 6'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_count  <= 6'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= 32'd0;
            r_count  <= 6'(STEPS);
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_acc    <= r_acc + w_partial;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_count  <= w_count_next;
          if (w_count_next == 6'd0) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == BUSY);
  assign o_done    = (r_state == DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, branch resolution, EX/MEM output register and
// pipeline stall control around the iterative multiplier.
module exe_stage
  import mips_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Val1_in,
  input  logic [31:0] Val2_in,
  input  logic [31:0] Reg2_in,
  input  logic [31:0] PC_in,
  input  logic [1:0]  br_type_in,
  input  logic [3:0]  EXE_CMD_in,
  input  logic [4:0]  Dest_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        WB_EN_in,
  output logic        stall,
  output logic        Br_taken,
  output logic [31:0] Br_addr,
  output logic [31:0] ALU_result,
  output logic [31:0] Reg2_out,
  output logic [4:0]  Dest_out,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        WB_EN
);

  logic        w_is_mul;
  logic        w_busy;
  logic        w_done;
  logic        w_idle;
  logic        w_start;
  logic        w_br_cond;
  logic [31:0] w_alu;
  logic [31:0] w_product;

  logic [31:0] r_alu;
  logic [31:0] r_reg2;
  logic [4:0]  r_dest;
  logic        r_mem_r;
  logic        r_mem_w;
  logic        r_wb;

  assign w_is_mul = (EXE_CMD_in == EXE_MUL);
  assign w_idle   = !w_busy && !w_done;
  assign w_start  = w_idle && w_is_mul;
  assign w_alu    = alu_compute(EXE_CMD_in, Val1_in, Val2_in);

  iter_multiplier #(
    .BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_a      (Val1_in),
    .i_b      (Val2_in),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_product(w_product)
  );

  always_comb begin
    w_br_cond = 1'b0;
    case (br_type_in)
      BR_BEZ:  w_br_cond = (Val1_in == 32'd0);
      BR_BNE:  w_br_cond = (Val1_in != Val2_in);
      BR_JMP:  w_br_cond = 1'b1;
      default: w_br_cond = 1'b0;
    endcase
  end

  // Branches resolve only for a fresh non-MUL instruction; a MUL in DONE
  // must not redirect fetch with its still-held ID/EX fields.
  assign stall    = w_start || w_busy;
  assign Br_taken = w_idle && !w_is_mul && w_br_cond;
  assign Br_addr  = (br_type_in == BR_JMP) ? Val2_in : (PC_in + (Val2_in << 2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu   <= 32'd0;
      r_reg2  <= 32'd0;
      r_dest  <= 5'd0;
      r_mem_r <= 1'b0;
      r_mem_w <= 1'b0;
      r_wb    <= 1'b0;
    end else if (stall) begin
      r_mem_r <= 1'b0;
      r_mem_w <= 1'b0;
      r_wb    <= 1'b0;
    end else begin
      r_alu   <= w_done ? w_product : w_alu;
      r_reg2  <= Reg2_in;
      r_dest  <= Dest_in;
      r_mem_r <= MEM_R_EN_in;
      r_mem_w <= MEM_W_EN_in;
      r_wb    <= WB_EN_in;
    end
  end

  assign ALU_result = r_alu;
  assign Reg2_out   = r_reg2;
  assign Dest_out   = r_dest;
  assign MEM_R_EN   = r_mem_r;
  assign MEM_W_EN   = r_mem_w;
  assign WB_EN      = r_wb;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: one instance at 1 multiplier bit per cycle
// and one at 4, sharing stimulus; a mux selects which one the monitor checks.
module tb_exe_stage;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [31:0] reg2;
    logic [4:0]  dest;
    logic        wb;
    logic        memR;
    logic        memW;
    int          issueEdge;
    int          lat;
    int          stalls;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Val1_in, Val2_in, Reg2_in, PC_in;
  logic [1:0]  br_type_in;
  logic [3:0]  EXE_CMD_in;
  logic [4:0]  Dest_in;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;

  logic        stall1, brTaken1, memR1, memW1, wb1;
  logic [31:0] brAddr1, alu1, reg2o1;
  logic [4:0]  dest1;
  logic        stall4, brTaken4, memR4, memW4, wb4;
  logic [31:0] brAddr4, alu4, reg2o4;
  logic [4:0]  dest4;

  logic        mStall, mBrTaken, mMemR, mMemW, mWb;
  logic [31:0] mBrAddr, mAlu, mReg2;
  logic [4:0]  mDest;

  logic    sel = 1'b0;
  logic    monitorOn = 1'b0;
  logic    instValid = 1'b0;
  logic    retired = 1'b0;
  int      edgeCount = 0;
  int      stallCnt = 0;
  int      testCount = 0;
  int      failCount = 0;
  expect_t sbQueue[$];
  string   nameQ[$];

  exe_stage #(.MUL_BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .Val1_in(Val1_in), .Val2_in(Val2_in), .Reg2_in(Reg2_in),
    .PC_in(PC_in), .br_type_in(br_type_in), .EXE_CMD_in(EXE_CMD_in), .Dest_in(Dest_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .stall(stall1), .Br_taken(brTaken1), .Br_addr(brAddr1), .ALU_result(alu1),
    .Reg2_out(reg2o1), .Dest_out(dest1), .MEM_R_EN(memR1), .MEM_W_EN(memW1), .WB_EN(wb1)
  );

  exe_stage #(.MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .Val1_in(Val1_in), .Val2_in(Val2_in), .Reg2_in(Reg2_in),
    .PC_in(PC_in), .br_type_in(br_type_in), .EXE_CMD_in(EXE_CMD_in), .Dest_in(Dest_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .stall(stall4), .Br_taken(brTaken4), .Br_addr(brAddr4), .ALU_result(alu4),
    .Reg2_out(reg2o4), .Dest_out(dest4), .MEM_R_EN(memR4), .MEM_W_EN(memW4), .WB_EN(wb4)
  );

  assign mStall   = sel ? stall4   : stall1;
  assign mBrTaken = sel ? brTaken4 : brTaken1;
  assign mBrAddr  = sel ? brAddr4  : brAddr1;
  assign mAlu     = sel ? alu4     : alu1;
  assign mReg2    = sel ? reg2o4   : reg2o1;
  assign mDest    = sel ? dest4    : dest1;
  assign mMemR    = sel ? memR4    : memR1;
  assign mMemW    = sel ? memW4    : memW1;
  assign mWb      = sel ? wb4      : wb1;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setInputs(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] reg2, input logic [31:0] pc, input logic [1:0] br,
                           input logic [4:0] dest, input logic memR, input logic memW,
                           input logic wb);
    EXE_CMD_in  = cmd;
    Val1_in     = v1;
    Val2_in     = v2;
    Reg2_in     = reg2;
    PC_in       = pc;
    br_type_in  = br;
    Dest_in     = dest;
    MEM_R_EN_in = memR;
    MEM_W_EN_in = memW;
    WB_EN_in    = wb;
  endtask

  // Called just after a falling edge; returns once the instruction retires.
  task automatic applyStimulus(input string name, input logic [3:0] cmd, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [31:0] reg2, input logic [31:0] pc,
                               input logic [1:0] br, input logic [4:0] dest, input logic memR,
                               input logic memW, input logic wb, input logic [31:0] expRes,
                               input int expLat, input int expStalls, input logic expTaken,
                               input logic checkAddr, input logic [31:0] expAddr);
    expect_t e;
    setInputs(cmd, v1, v2, reg2, pc, br, dest, memR, memW, wb);
    e.res = expRes; e.reg2 = reg2; e.dest = dest; e.wb = wb; e.memR = memR; e.memW = memW;
    e.issueEdge = edgeCount; e.lat = expLat; e.stalls = expStalls;
    sbQueue.push_back(e);
    nameQ.push_back(name);
    stallCnt  = 0;
    retired   = 1'b0;
    instValid = 1'b1;
    #1;
    checkOutput({name, "_brTaken"}, {31'd0, mBrTaken}, {31'd0, expTaken});
    if (checkAddr) checkOutput({name, "_brAddr"}, mBrAddr, expAddr);
    for (int i = 0; i < 200 && !retired; i++) @(negedge clk);
    if (!retired) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL %s_timeout: got no retirement expected one within 200 cycles", name);
      sbQueue.delete();
      nameQ.delete();
    end
    instValid = 1'b0;
  endtask

  task automatic aluOp(input string name, input logic [3:0] cmd, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [4:0] dest, input logic [31:0] expRes);
    applyStimulus(name, cmd, v1, v2, 32'h0, 32'h0, BR_NONE, dest, 1'b0, 1'b0, 1'b1,
                  expRes, 1, 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic branchOp(input string name, input logic [1:0] br, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] pc, input logic taken,
                          input logic [31:0] addr, input logic [31:0] expRes);
    applyStimulus(name, EXE_ADD, v1, v2, 32'h0, pc, br, 5'd0, 1'b0, 1'b0, 1'b0,
                  expRes, 1, 0, taken, 1'b1, addr);
  endtask

  task automatic mulOp(input string name, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [4:0] dest, input logic [31:0] expRes, input int bits,
                       input logic [1:0] br);
    applyStimulus(name, EXE_MUL, v1, v2, 32'h0000_0011, 32'h0, br, dest, 1'b0, 1'b0, 1'b1,
                  expRes, 2 + 32 / bits, 1 + 32 / bits, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_alu"},   mAlu, 32'h0);
    checkOutput({tag, "_dest"},  {27'd0, mDest}, 32'h0);
    checkOutput({tag, "_reg2"},  mReg2, 32'h0);
    checkOutput({tag, "_ctrl"},  {29'd0, mWb, mMemR, mMemW}, 32'h0);
    checkOutput({tag, "_stall"}, {31'd0, mStall}, 32'h0);
  endtask

  // Monitor: samples stall just before each rising edge and, after the
  // edge, either checks a bubble or pops and compares a retiring result.
  initial begin : monitor
    expect_t e;
    string   n;
    logic    wasStall, wasValid;
    forever begin
      @(negedge clk);
      #3;
      wasStall = mStall;
      wasValid = instValid && monitorOn;
      @(posedge clk);
      edgeCount++;
      #1;
      if (wasValid) begin
        if (wasStall) begin
          stallCnt++;
          checkOutput("bubble", {29'd0, mWb, mMemR, mMemW}, 32'h0);
        end else if (sbQueue.size() == 0) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL unexpected_retire: got result 0x%08h expected no retirement", mAlu);
        end else begin
          e = sbQueue.pop_front();
          n = nameQ.pop_front();
          checkOutput({n, "_result"},  mAlu, e.res);
          checkOutput({n, "_dest"},    {27'd0, mDest}, {27'd0, e.dest});
          checkOutput({n, "_reg2"},    mReg2, e.reg2);
          checkOutput({n, "_ctrl"},    {29'd0, mWb, mMemR, mMemW}, {29'd0, e.wb, e.memR, e.memW});
          checkOutput({n, "_latency"}, 32'(edgeCount - e.issueEdge), 32'(e.lat));
          checkOutput({n, "_stalls"},  32'(stallCnt), 32'(e.stalls));
          stallCnt = 0;
          retired  = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before 400000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b0;
    setInputs(EXE_ADD, 32'd5, 32'd7, 32'h0, 32'h0, BR_NONE, 5'd3, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkResetState("reset_initial");
    rst = 1'b1;
    monitorOn = 1'b1;

    aluOp("add",      EXE_ADD, 32'd5,          32'd7,          5'd3,  32'd12);
    aluOp("sub",      EXE_SUB, 32'h0000_0003,  32'h0000_0005,  5'd4,  32'hFFFF_FFFE);
    aluOp("sra",      EXE_SRA, 32'h8000_0000,  32'd4,          5'd5,  32'hF800_0000);
    aluOp("nor",      EXE_NOR, 32'h0,          32'h0,          5'd6,  32'hFFFF_FFFF);
    aluOp("srl",      EXE_SRL, 32'h8000_0000,  32'd4,          5'd7,  32'h0800_0000);
    aluOp("sll_31",   EXE_SLL, 32'h0000_0001,  32'h0000_003F,  5'd8,  32'h8000_0000);
    aluOp("and",      EXE_AND, 32'h0000_F0F0,  32'h0000_FF00,  5'd10, 32'h0000_F000);
    aluOp("or",       EXE_OR,  32'h0000_F0F0,  32'h0000_0F0F,  5'd11, 32'h0000_FFFF);
    aluOp("xor",      EXE_XOR, 32'h0000_00FF,  32'h0000_000F,  5'd12, 32'h0000_00F0);
    aluOp("add_wrap", EXE_ADD, 32'hFFFF_FFFF,  32'h0000_0001,  5'd13, 32'h0);
    aluOp("undef",    4'b0011, 32'h1234_5678,  32'h1111_1111,  5'd14, 32'h0);
    applyStimulus("store", EXE_ADD, 32'h0000_1000, 32'd8, 32'hDEAD_BEEF, 32'h0, BR_NONE,
                  5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_1008, 1, 0, 1'b0, 1'b0, 32'h0);

    branchOp("bne_taken",  BR_BNE, 32'd1, 32'd2,     32'h100, 1'b1, 32'h108, 32'd3);
    branchOp("bne_equal",  BR_BNE, 32'd5, 32'd5,     32'h100, 1'b0, 32'h114, 32'd10);
    branchOp("bez_nz",     BR_BEZ, 32'd3, 32'd1,     32'h100, 1'b0, 32'h104, 32'd4);
    branchOp("bez_taken",  BR_BEZ, 32'd0, 32'd4,     32'h200, 1'b1, 32'h210, 32'd4);
    branchOp("jmp",        BR_JMP, 32'd0, 32'h40,    32'h300, 1'b1, 32'h40,  32'h40);

    // Asynchronous reset in the middle of a cycle while a result is held.
    monitorOn = 1'b0;
    @(negedge clk);
    setInputs(EXE_ADD, 32'd1, 32'd1, 32'h55, 32'h0, BR_NONE, 5'd4, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkResetState("reset_async");
    repeat (2) @(negedge clk);
    checkResetState("reset_held");
    rst = 1'b1;
    monitorOn = 1'b1;
    aluOp("add_after_rst", EXE_ADD, 32'd5, 32'd7, 5'd3, 32'd12);

    mulOp("mul_ffff_x3",  32'hFFFF_FFFF, 32'd3,        5'd9,  32'hFFFF_FFFD, 1, BR_JMP);
    mulOp("mul_6x7",      32'd6,         32'd7,        5'd15, 32'd42,        1, BR_NONE);
    mulOp("mul_wrap",     32'h0001_0000, 32'h0001_0000, 5'd16, 32'h0,        1, BR_NONE);
    mulOp("mul_neg2x5",   32'hFFFF_FFFE, 32'd5,        5'd17, 32'hFFFF_FFF6, 1, BR_NONE);
    aluOp("add_after_mul", EXE_ADD, 32'd2, 32'd3, 5'd18, 32'd5);

    // Reset during BUSY: the aborted product must never reach the output.
    monitorOn = 1'b0;
    @(negedge clk);
    setInputs(EXE_MUL, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'h0, BR_NONE, 5'd9, 1'b0, 1'b0, 1'b1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_stall", {31'd0, mStall}, 32'd1);
    rst = 1'b0;
    #1;
    setInputs(EXE_ADD, 32'h0, 32'h0, 32'h0, 32'h0, BR_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checkResetState("reset_busy");
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checkResetState("no_late_product");

    sel = 1'b1;
    monitorOn = 1'b1;
    mulOp("mul4_6x7",   32'd6,         32'd7,         5'd20, 32'd42,        4, BR_NONE);
    mulOp("mul4_wrap",  32'h0001_0000, 32'h0001_0000, 5'd21, 32'h0,         4, BR_NONE);
    mulOp("mul4_mixed", 32'h1234_5678, 32'd9,         5'd22, 32'hA3D7_0A38, 4, BR_NONE);
    mulOp("mul4_allf",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23, 32'h0000_0001, 4, BR_NONE);
    aluOp("add4_after", EXE_ADD, 32'd100, 32'd23, 5'd24, 32'd123);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
